mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 data-selection path between four requesters.
- Each requester owns one data input (d0..d3).
- The arbiter decides which requester owns the path, drives the registered select lines s1/s0, and gates the selected bit onto y.
- It sits in front of the 4:1 mux datapath as its sequencing/sharing controller.

Parameters:
- QUANTUM, 4: maximum consecutive cycles one requester keeps the grant while others wait. Legal range 1..15.
- CNT_W, 4: width of the hold counter; must satisfy 2**CNT_W > QUANTUM.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous reset, active-high
- req  input  4  request lines; bit i = requester i wants the path
- d0   input  1  data bit of requester 0
- d1   input  1  data bit of requester 1
- d2   input  1  data bit of requester 2
- d3   input  1  data bit of requester 3
- grant  output  4  one-hot grant, registered
- valid  output  1  high while some requester owns the path, registered
- s0   output  1  select LSB (owner index bit 0), registered
- s1   output  1  select MSB (owner index bit 1), registered
- y    output  1  selected data: d[{s1,s0}] when valid, else 0 (combinational from registered select)

Behaviour:
- Clock and reset: single clock domain clk; rst is synchronous, active-high. All state updates on the rising edge of clk.
- Reset values (rst high at an edge): grant=4'b0000, valid=0, s1=0, s0=0, y=0, round-robin pointer ptr=0, hold counter cnt=0, state=IDLE.
- States:
  - IDLE: no owner.
  - GRANT: owner index held in {s1,s0}.
- Pick function: first i with req[i]=1, scanning start, start+1, ... mod 4. Wraps 3→0.
- IDLE, req==0: stay IDLE; outputs unchanged (grant=0, valid=0; s1/s0 keep last value).
- IDLE, req!=0:
  - At the edge, owner = pick(ptr); grant=onehot(owner), {s1,s0}=owner, valid=1, cnt=1, state→GRANT.
  - Latency: req high before edge k → grant visible right after edge k.
- GRANT, owner's req still high, and (cnt<QUANTUM or no other req bit set): keep owner; cnt increments, saturating at QUANTUM.
- GRANT, owner's req still high, cnt==QUANTUM, another req set:
  - Rotate: new owner = pick(owner+1); cnt=1.
  - No idle bubble between the two grants.
- GRANT, owner's req low:
  - If other req set: new owner = pick(owner+1); cnt=1; no bubble.
  - Else: state→IDLE, grant=0, valid=0, cnt=0; s1/s0 hold.
- ptr update: ptr = (owner+1) mod 4 every time a new owner is granted. ptr is unchanged while the same owner holds.
- Grant invariants: grant is always one-hot or zero, and grant[{s1,s0}]==valid.
- y is never driven from a non-granted input. y=0 whenever valid=0.
- Reset mid-grant: rst overrides all other conditions at that edge; the next cycle shows reset values regardless of req.
- QUANTUM=1 with all four requesting: grant rotates every cycle.

Decomposition:
- Shared include file (team constants) holds:
  - NREQ=4
  - State encoding ST_IDLE=1'b0, ST_GRANT=1'b1
  - Default QUANTUM
- Sub-module rr_pick: combinational. Inputs req[3:0] and start[1:0]; outputs idx[1:0] and any. Instantiated once, with start muxed between ptr (from IDLE) and owner+1 (from GRANT).
- Data selection for y stays in the top level: a 4:1 selection of d0..d3 by {s1,s0}, ANDed with valid.

Test Plan:
- Reset then idle: hold rst=1 two cycles, then req=0000 for 5 cycles → grant=0000, valid=0, s1s0=00, y=0 throughout.
- Single requester: req=0100, d2=1 → after the next edge grant=0100, s1s0=10, valid=1, y=1. Toggle d2 to 0 → y=0 the same cycle. Drop req → after the next edge valid=0, grant=0000.
- Fairness, QUANTUM=4, req=1111 from reset → owners 0,1,2,3,0 in that order, each held exactly 4 cycles, no gap cycles.
- Early release with wrap-around: owner=3, req 1111→0111 → after the next edge grant=0001 (wrap 3→0), cnt=1.
- Lone requester beyond quantum: req=0010 for 10 cycles → grant stays 0010 all 10 cycles, cnt saturates at 4.
- Reset mid-operation: during grant=0010 assert rst for one edge with req=1111 → next cycle grant=0000, valid=0, s1s0=00. After rst drops, the first grant is 0001 (ptr=0).

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg
// Shared constants and types for the round-robin mux arbiter.
//   NREQ            : number of requesters sharing the 4:1 path
//   IDX_W           : width of an owner / requester index
//   DEFAULT_QUANTUM : default number of consecutive cycles an owner may hold
//   arbState_e      : arbiter FSM state encoding
//   oneHot()        : converts an owner index into a one-hot grant vector
package mux_rr_arbiter_pkg;

  localparam int NREQ            = 4;
  localparam int IDX_W           = 2;
  localparam int DEFAULT_QUANTUM = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arbState_e;

  // One-hot decode of an owner index, used both for the registered grant
  // and for masking the owner out of the request vector.
  function automatic logic [NREQ-1:0] oneHot(input logic [IDX_W-1:0] idx);
    return {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker: finds the first asserted request bit
// scanning start, start+1, ... modulo NREQ.
//   req   : request vector
//   start : index at which the scan begins
//   idx   : index of the first asserted request found
//   any   : high when at least one request bit is set
module rr_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [NREQ-1:0]  w_rot;
  logic [IDX_W-1:0] w_offset;

  // Rotate the request vector so that bit 0 corresponds to the start
  // position; the index arithmetic wraps naturally in IDX_W bits.
  always_comb begin
    w_rot = '0;
    for (int j = 0; j < NREQ; j++) begin
      w_rot[j] = req[IDX_W'(32'(start) + j)];
    end
  end

  // Fixed-priority encode of the rotated vector, lowest bit wins. Scanning
  // downwards lets the lowest set bit be the last (and winning) assignment.
  always_comb begin
    w_offset = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_offset = IDX_W'(j);
      end
    end
  end

  // Undo the rotation to get an absolute requester index.
  assign idx = start + w_offset;
  assign any = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter sharing one 4:1 data-selection path between four
// requesters. An owner keeps the path for at most QUANTUM consecutive
// cycles while others wait; a lone requester may hold it indefinitely.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   req[3:0]   : request lines, bit i = requester i wants the path
//   d0..d3     : data bit of each requester
//   grant[3:0] : registered one-hot grant (zero when idle)
//   valid      : registered, high while some requester owns the path
//   s1, s0     : registered select lines = owner index
//   y          : d[{s1,s0}] gated by valid
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int QUANTUM = DEFAULT_QUANTUM,
  parameter int CNT_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            d0,
  input  logic            d1,
  input  logic            d2,
  input  logic            d3,
  output logic [NREQ-1:0] grant,
  output logic            valid,
  output logic            s0,
  output logic            s1,
  output logic            y
);

  localparam logic [CNT_W-1:0] QMAX    = CNT_W'(QUANTUM);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arbState_e        r_state;
  logic [IDX_W-1:0] r_owner;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [NREQ-1:0]  r_grant;
  logic             r_valid;

  arbState_e        w_stateNext;
  logic [IDX_W-1:0] w_ownerNext;
  logic [IDX_W-1:0] w_ptrNext;
  logic [CNT_W-1:0] w_cntNext;
  logic [NREQ-1:0]  w_grantNext;
  logic             w_validNext;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_pickIdx;
  logic             w_pickAny;
  logic             w_ownerReq;
  logic             w_othersReq;
  logic [NREQ-1:0]  w_dataVec;

  // From IDLE the scan starts at the round-robin pointer; while granting it
  // starts just past the current owner, so the owner itself is considered
  // last and only wins when nobody else is asking.
  assign w_start     = (r_state == ST_IDLE) ? r_ptr : r_owner + 2'd1;
  assign w_ownerReq  = req[r_owner];
  assign w_othersReq = |(req & ~oneHot(r_owner));

  rr_pick uPick (
    .req   (req),
    .start (w_start),
    .idx   (w_pickIdx),
    .any   (w_pickAny)
  );

  // State register: all arbiter state, with reset taking priority over
  // every other condition at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_owner <= w_ownerNext;
      r_ptr   <= w_ptrNext;
      r_cnt   <= w_cntNext;
      r_grant <= w_grantNext;
      r_valid <= w_validNext;
    end
  end

  // Next-state logic. Every hand-over (from IDLE or between owners) takes
  // the picker result directly, so there is never an idle bubble between
  // two grants. The pointer only moves when a new owner is granted.
  always_comb begin
    w_stateNext = r_state;
    w_ownerNext = r_owner;
    w_ptrNext   = r_ptr;
    w_cntNext   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pickAny) begin
          w_stateNext = ST_GRANT;
          w_ownerNext = w_pickIdx;
          w_ptrNext   = w_pickIdx + 2'd1;
          w_cntNext   = CNT_ONE;
        end
      end
      ST_GRANT: begin
        if (w_ownerReq && ((r_cnt < QMAX) || !w_othersReq)) begin
          if (r_cnt < QMAX) begin
            w_cntNext = r_cnt + CNT_ONE;
          end
        end else if (w_othersReq) begin
          w_ownerNext = w_pickIdx;
          w_ptrNext   = w_pickIdx + 2'd1;
          w_cntNext   = CNT_ONE;
        end else begin
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Output logic. Grant and valid are derived from the next state so they
  // can be registered alongside it; y is a 4:1 selection by the registered
  // select lines, forced low whenever nobody owns the path.
  always_comb begin
    w_validNext = (w_stateNext == ST_GRANT);
    w_grantNext = w_validNext ? oneHot(w_ownerNext) : '0;
    w_dataVec   = {d3, d2, d1, d0};
    y           = w_dataVec[r_owner] & r_valid;
  end

  assign grant = r_grant;
  assign valid = r_valid;
  assign s1    = r_owner[1];
  assign s0    = r_owner[0];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
// Self-checking bench for mux_rr_arbiter: a table of single-step vectors
// followed by hand-written multi-cycle sequences (fairness, early release
// with wrap-around, lone requester saturation, reset mid-grant). A second
// instance with QUANTUM=1 shares the inputs to show per-cycle rotation.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       d0, d1, d2, d3;
  logic [3:0] grant;
  logic       valid, s0, s1, y;
  logic [3:0] grantQ1;
  logic       validQ1, s0Q1, s1Q1, yQ1;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    logic       rst;
    logic       edgeEn;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] expGrant;
    logic       expValid;
    logic [1:0] expSel;
    logic       expY;
  } vec_t;

  vec_t vecs[16];

  mux_rr_arbiter #(.QUANTUM(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .d0    (d0),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .grant (grant),
    .valid (valid),
    .s0    (s0),
    .s1    (s1),
    .y     (y)
  );

  mux_rr_arbiter #(.QUANTUM(1), .CNT_W(4)) dutQ1 (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .d0    (d0),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .grant (grantQ1),
    .valid (validQ1),
    .s0    (s0Q1),
    .s1    (s1Q1),
    .y     (yQ1)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ohTb(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  // Drive inputs, then either take a clock edge and settle 1 time unit past
  // it, or just let the combinational path settle without an edge.
  task automatic applyStimulus(input logic r, input logic e,
                               input logic [3:0] rq, input logic [3:0] dd);
    rst = r;
    req = rq;
    {d3, d2, d1, d0} = dd;
    if (e) begin
      @(posedge clk);
      #1;
    end else begin
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg,
                             input logic ev, input logic [1:0] es,
                             input logic ey);
    testsRun++;
    if (grant !== eg) begin
      failCount++;
      $display("[TB] FAIL %s grant got %b want %b", name, grant, eg);
    end
    testsRun++;
    if (valid !== ev) begin
      failCount++;
      $display("[TB] FAIL %s valid got %b want %b", name, valid, ev);
    end
    testsRun++;
    if ({s1, s0} !== es) begin
      failCount++;
      $display("[TB] FAIL %s sel got %b want %b", name, {s1, s0}, es);
    end
    testsRun++;
    if (y !== ey) begin
      failCount++;
      $display("[TB] FAIL %s y got %b want %b", name, y, ey);
    end
  endtask

  task automatic checkQ1(input string name, input logic [3:0] eg);
    testsRun++;
    if (grantQ1 !== eg) begin
      failCount++;
      $display("[TB] FAIL %s q1 grant got %b want %b", name, grantQ1, eg);
    end
  endtask

  initial begin
    logic [3:0] dd;
    int         own;

    rst = 1'b1;
    req = 4'b0000;
    {d3, d2, d1, d0} = 4'b0000;

    // rst edge, req, d, edge, expGrant, expValid, expSel, expY
    vecs[0]  = '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 4'b0100, 4'b1011, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd2, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 4'b0010, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 4'b1001, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 4'b0011, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1};

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].edgeEn, vecs[i].req, vecs[i].d);
      checkOutput($sformatf("vec%0d", i), vecs[i].expGrant, vecs[i].expValid,
                  vecs[i].expSel, vecs[i].expY);
    end

    // Fairness from reset with everyone requesting: QUANTUM=4 gives owners
    // 0,1,2,3 for four cycles each, QUANTUM=1 rotates every cycle.
    applyStimulus(1'b1, 1'b1, 4'b1111, 4'b0000);
    checkOutput("fairRst", 4'b0000, 1'b0, 2'd0, 1'b0);
    checkQ1("fairRst", 4'b0000);
    for (int k = 0; k < 16; k++) begin
      dd  = 4'($urandom_range(0, 15));
      applyStimulus(1'b0, 1'b1, 4'b1111, dd);
      own = (k / 4) % 4;
      checkOutput($sformatf("fair%0d", k), ohTb(own), 1'b1, 2'(own), dd[own]);
      checkQ1($sformatf("fair%0d", k), ohTb(k % 4));
    end

    // Owner 3 releases: hand-over wraps to 0 with a fresh count, so owner 0
    // holds four cycles before rotating to 1.
    for (int k = 0; k < 5; k++) begin
      dd  = 4'($urandom_range(0, 15));
      applyStimulus(1'b0, 1'b1, 4'b0111, dd);
      own = (k < 4) ? 0 : 1;
      checkOutput($sformatf("wrap%0d", k), ohTb(own), 1'b1, 2'(own), dd[own]);
    end

    // Lone requester 1 keeps the grant well beyond the quantum.
    for (int k = 0; k < 10; k++) begin
      dd = 4'($urandom_range(0, 15));
      applyStimulus(1'b0, 1'b1, 4'b0010, dd);
      checkOutput($sformatf("lone%0d", k), 4'b0010, 1'b1, 2'd1, dd[1]);
    end
    // Count saturated at the quantum, so a newcomer forces an immediate
    // rotation: scan from 2 wraps round to requester 0.
    applyStimulus(1'b0, 1'b1, 4'b0011, 4'b0001);
    checkOutput("loneSat", 4'b0001, 1'b1, 2'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'b0010, 4'b0010);
    checkOutput("handTo1", 4'b0010, 1'b1, 2'd1, 1'b1);

    // Reset mid-grant wins over requests; the pointer returns to 0.
    applyStimulus(1'b1, 1'b1, 4'b1111, 4'b1111);
    checkOutput("midRst", 4'b0000, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1111, 4'b0001);
    checkOutput("afterRst", 4'b0001, 1'b1, 2'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
